// File: rtl/controle_subtrator_serial.sv
// Bit-serial subtractor S = A - B, one full-subtractor cell reused LSB first; start -> done takes N+1 edges.
// No backpressure: start is sampled only in IDLE, and done is a one-cycle pulse that the consumer must catch.
module controle_subtrator_serial #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N:0]   S,
    output logic         busy,
    output logic         done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_borrow;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_shift;
    logic [N:0]    r_s;

    logic          w_a_bit;
    logic          w_b_bit;
    logic          w_d;
    logic          w_bout;
    logic          w_last;
    logic [N-1:0]  w_shift_nxt;

    assign w_a_bit     = r_a[r_cnt];
    assign w_b_bit     = r_b[r_cnt];
    assign w_d         = w_a_bit ^ w_b_bit ^ r_borrow;
    assign w_bout      = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_borrow);
    assign w_last      = (r_cnt == CNT_LAST);
    // Difference bits enter at the MSB, so after N shifts bit 0 sits at the LSB.
    assign w_shift_nxt = {w_d, r_shift[N-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_nxt = CALC;
            CALC:    if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_shift  <= '0;
            r_s      <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_cnt    <= '0;
                        r_borrow <= 1'b0;
                    end
                end
                CALC: begin
                    r_shift  <= w_shift_nxt;
                    r_borrow <= w_bout;
                    if (w_last) begin
                        r_s <= {w_bout, w_shift_nxt};
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign S    = r_s;
    assign busy = (r_state == CALC);
    assign done = (r_state == DONE);

endmodule

// File: tb/tb_controle_subtrator_serial.sv
// Directed-vector bench for the bit-serial subtractor with N = 8.
module tb_controle_subtrator_serial;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N:0]   S;
    logic         busy;
    logic         done;

    int vectors;
    int miscompares;

    controle_subtrator_serial #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .S     (S),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (S !== 9'h000) begin
            miscompares++;
            $display("FAIL reset_S: got %h expected %h", S, 9'h000);
        end
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got busy=%b done=%b expected 0 0", busy, done);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One operation: N busy cycles, then a done cycle with the result, then S held in IDLE.
    task automatic test_op(input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N:0] prev_s, input logic [N:0] exp_s);
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        A = ~a;
        B = ~b;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL op_calc[%0d] a=%h b=%h: got busy=%b done=%b expected 1 0",
                         i, a, b, busy, done);
            end
            if (i == 0) begin
                vectors++;
                if (S !== prev_s) begin
                    miscompares++;
                    $display("FAIL op_hold a=%h b=%h: got %h expected %h", a, b, S, prev_s);
                end
            end
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || S !== exp_s) begin
            miscompares++;
            $display("FAIL op_done a=%h b=%h: got S=%h done=%b busy=%b expected S=%h done=1 busy=0",
                     a, b, S, done, busy, exp_s);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || S !== exp_s) begin
            miscompares++;
            $display("FAIL op_after a=%h b=%h: got S=%h done=%b busy=%b expected S=%h done=0 busy=0",
                     a, b, S, done, busy, exp_s);
        end
    endtask

    task automatic test_vectors();
        test_op(8'h50, 8'h20, 9'h000, 9'h030);
        test_op(8'h20, 8'h50, 9'h030, 9'h1D0);
        test_op(8'h00, 8'h01, 9'h1D0, 9'h1FF);
        test_op(8'hFF, 8'hFF, 9'h1FF, 9'h000);
        test_op(8'hFF, 8'h00, 9'h000, 9'h0FF);
    endtask

    task automatic test_start_ignored();
        int n_done;
        n_done = 0;
        A      = 8'h10;
        B      = 8'h01;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < N + 4; i++) begin
            if (i == 2) begin
                start = 1'b1;
                A     = 8'h00;
                B     = 8'hFF;
            end else if (i > 2) begin
                start = 1'b0;
                A     = 8'(i * 37);
                B     = 8'(i * 91);
            end
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                vectors++;
                if (S !== 9'h00F) begin
                    miscompares++;
                    $display("FAIL ignored_result: got %h expected %h", S, 9'h00F);
                end
            end
        end
        vectors++;
        if (n_done != 1) begin
            miscompares++;
            $display("FAIL ignored_done_count: got %0d expected 1", n_done);
        end
        vectors++;
        if (busy !== 1'b0 || S !== 9'h00F) begin
            miscompares++;
            $display("FAIL ignored_idle: got busy=%b S=%h expected busy=0 S=%h", busy, S, 9'h00F);
        end
    endtask

    task automatic test_async_reset();
        A     = 8'h77;
        B     = 8'h11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (S !== 9'h000 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got S=%h busy=%b done=%b expected 000 0 0", S, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_op(8'h03, 8'h05, 9'h000, 9'h1FE);
    endtask

    task automatic test_back_to_back();
        int n_done;
        int last_done;
        n_done    = 0;
        last_done = -1;
        A         = 8'h09;
        B         = 8'h04;
        start     = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            vectors++;
            if (busy === 1'b1 && done === 1'b1) begin
                miscompares++;
                $display("FAIL b2b_overlap[%0d]: got busy=1 done=1 expected not both", i);
            end
            if (done === 1'b1) begin
                n_done++;
                vectors++;
                if (S !== 9'h005) begin
                    miscompares++;
                    $display("FAIL b2b_result[%0d]: got %h expected %h", i, S, 9'h005);
                end
                if (last_done >= 0) begin
                    vectors++;
                    if (i - last_done != N + 2) begin
                        miscompares++;
                        $display("FAIL b2b_interval: got %0d expected %0d", i - last_done, N + 2);
                    end
                end
                last_done = i;
            end
        end
        start = 1'b0;
        vectors++;
        if (n_done != 3) begin
            miscompares++;
            $display("FAIL b2b_done_count: got %0d expected 3", n_done);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_vectors();
        test_start_ignored();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
